// File: rtl/bank_pkg.sv
// Shared widths and state encoding for the bank word sequencer and decoder.
package bank_pkg;

    localparam int BANK_ADDR_W = 10;
    localparam int BANK_LEN_W  = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } bank_seq_state_t;

endpackage

// File: rtl/bank_word_sequencer.sv
// Burst word-select sequencer feeding the bank word decoder; strobes lag sel by one
// cycle to line up with the decoder's registered one-hot output.
module bank_word_sequencer
    import bank_pkg::*;
#(
    parameter int ADDR_W = BANK_ADDR_W,
    parameter int LEN_W  = BANK_LEN_W
) (
`ifdef USE_POWER_PINS
    inout  wire               vccd1,
    inout  wire               vssd1,
`endif
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              hold,
    output logic [ADDR_W-1:0] sel,
    output logic              sel_valid,
    output logic              word_en,
    output logic              word_we,
    output logic              busy,
    output logic              done
);

    bank_seq_state_t   state_q, state_d;
    logic [ADDR_W-1:0] sel_q, sel_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              write_q, write_d;
    logic              sel_valid_q, sel_valid_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              word_en_q, word_en_d;
    logic              word_we_q, word_we_d;
    logic              done_q, done_d;
    logic              last_beat;

    assign last_beat = (cnt_q == len_q);

    // A beat is consumed on the edge that closes a cycle with sel_valid_q high, so
    // hold only shapes the next cycle's sel_valid and never reaches an output directly.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        write_d = write_q;
        case (state_q)
            IDLE: begin
                if (req_valid && ready_q) begin
                    state_d = RUN;
                    sel_d   = req_addr;
                    cnt_d   = '0;
                    len_d   = req_len;
                    write_d = req_write;
                end
            end
            RUN: begin
                if (sel_valid_q) begin
                    if (last_beat) begin
                        state_d = DRAIN;
                    end else begin
                        sel_d = sel_q + ADDR_W'(1);
                        cnt_d = cnt_q + LEN_W'(1);
                    end
                end
            end
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        sel_valid_d = (state_d == RUN) && ((state_q == IDLE) || !hold);
        ready_d     = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        word_en_d   = sel_valid_q;
        word_we_d   = sel_valid_q && write_q;
        done_d      = sel_valid_q && (state_q == RUN) && last_beat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            write_q     <= 1'b0;
            sel_valid_q <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            word_en_q   <= 1'b0;
            word_we_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            write_q     <= write_d;
            sel_valid_q <= sel_valid_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            word_en_q   <= word_en_d;
            word_we_q   <= word_we_d;
            done_q      <= done_d;
        end
    end

    assign req_ready = ready_q;
    assign sel       = sel_q;
    assign sel_valid = sel_valid_q;
    assign busy      = busy_q;
    assign word_en   = word_en_q;
    assign word_we   = word_we_q;
    assign done      = done_q;

endmodule

// File: tb/tb_bank_word_sequencer.sv
// Directed bench for bank_word_sequencer: bursts, wrap, hold, full length, mid-burst reset.
module tb_bank_word_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_write = 1'b0;
    logic [9:0] req_addr = '0;
    logic [9:0] req_len = '0;
    logic       hold = 1'b0;
    logic [9:0] sel;
    logic       sel_valid;
    logic       word_en;
    logic       word_we;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    bank_word_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .hold      (hold),
        .sel       (sel),
        .sel_valid (sel_valid),
        .word_en   (word_en),
        .word_we   (word_we),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issues one burst at a negedge and follows it to the first idle cycle after DRAIN.
    // Inputs change on negedges; outputs are sampled on negedges.
    task automatic run_burst(input int addr, input int len, input bit wr,
                             input int hold_after, input int hold_cyc);
        int   beats     = len + 1;
        int   issued    = 0;
        int   enc       = 0;
        int   dones     = 0;
        int   bubbles   = 0;
        int   cyc       = 0;
        int   hold_left = hold_cyc;
        bit   fin       = 0;
        logic pv        = 1'b0;
        logic [9:0] ps  = '0;

        @(negedge clk);
        chk("ready_before", req_ready, 1);
        req_valid = 1'b1;
        req_addr  = 10'(addr);
        req_len   = 10'(len);
        req_write = wr;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 10'($urandom);
        req_len   = 10'($urandom);
        req_write = ~wr;
        while (!fin && cyc < 2000) begin
            cyc++;
            if (cyc == 1) chk("ready_in_run", req_ready, 0);
            chk("busy_in_burst", busy, 1);
            chk("word_en_align", word_en, pv);
            chk("word_we_align", word_we, pv & wr);
            if (word_en) begin
                chk("en_index", ps, (addr + enc) % 1024);
                enc++;
            end
            if (done) begin
                dones++;
                fin = 1;
                chk("done_on_last_en", enc, beats);
                chk("done_cycle", cyc, beats + 1 + hold_cyc);
            end
            if (sel_valid) begin
                chk("sel_value", sel, (addr + issued) % 1024);
                issued++;
            end else if (!done && issued > 0 && issued < beats) begin
                bubbles++;
                chk("sel_frozen", sel, (addr + issued) % 1024);
            end
            pv = sel_valid;
            ps = sel;
            if (hold_left > 0 && issued >= hold_after) begin
                hold = 1'b1;
                hold_left--;
            end else begin
                hold = 1'b0;
            end
            @(negedge clk);
        end
        hold = 1'b0;
        if (!fin) chk("burst_timeout", 0, 1);
        chk("beats_issued", issued, beats);
        chk("done_count", dones, 1);
        chk("hold_bubbles", bubbles, hold_cyc);
        chk("ready_after", req_ready, 1);
        chk("busy_after", busy, 0);
        chk("sel_held", sel, (addr + len) % 1024);
        chk("en_after", word_en, 0);
        chk("done_after", done, 0);
    endtask

    initial begin
        @(negedge clk);
        chk("rst_ready", req_ready, 1);
        chk("rst_sel", sel, 0);
        chk("rst_sel_valid", sel_valid, 0);
        chk("rst_word_en", word_en, 0);
        chk("rst_word_we", word_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_burst(5, 0, 1'b0, 1 << 30, 0);
        run_burst(10, 3, 1'b1, 1 << 30, 0);
        run_burst(1022, 3, 1'b0, 1 << 30, 0);
        run_burst(300, 7, 1'b1, 2, 3);
        run_burst(0, 1023, 1'b1, 1 << 30, 0);

        // Mid-burst reset during beat 3 of a 6-beat write.
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 10'd100;
        req_len   = 10'd5;
        req_write = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("mr_beat1", sel, 100);
        @(negedge clk);
        chk("mr_beat2", sel, 101);
        @(negedge clk);
        chk("mr_beat3", sel, 102);
        chk("mr_beat3_valid", sel_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mr_sel", sel, 0);
        chk("mr_sel_valid", sel_valid, 0);
        chk("mr_word_en", word_en, 0);
        chk("mr_word_we", word_we, 0);
        chk("mr_busy", busy, 0);
        chk("mr_done", done, 0);
        chk("mr_ready", req_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mr_no_done", done, 0);
            chk("mr_idle_ready", req_ready, 1);
            chk("mr_idle_valid", sel_valid, 0);
        end
        run_burst(200, 1, 1'b0, 1 << 30, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
